// File: rtl/m2v_side_defs_pkg.sv
// Shared side-information definitions for the m2vside stages: block counts,
// default field widths and the common header layout.
package m2v_side_defs_pkg;

   localparam int unsigned NUM_BLOCKS    = 6;
   localparam logic [2:0]  BLK_LAST      = 3'd5;
   localparam int unsigned MVH_WIDTH_DEF = 16;
   localparam int unsigned MVV_WIDTH_DEF = 15;
   localparam int unsigned MBX_WIDTH_DEF = 6;
   localparam int unsigned MBY_WIDTH_DEF = 5;
   localparam int unsigned CBP_WIDTH     = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } side_state_t;

   // Header layout {mv_h, mv_v, x, y, intra, cbp} at default widths
   typedef struct packed {
      logic [MVH_WIDTH_DEF-1:0] mv_h;
      logic [MVV_WIDTH_DEF-1:0] mv_v;
      logic [MBX_WIDTH_DEF-1:0] x;
      logic [MBY_WIDTH_DEF-1:0] y;
      logic                     intra;
      logic [CBP_WIDTH-1:0]     cbp;
   } side_hdr_t;

   function automatic int unsigned hdr_width(input int unsigned mvh, input int unsigned mvv,
                                             input int unsigned mbx, input int unsigned mby);
      return mvh + mvv + mbx + mby + 1 + CBP_WIDTH;
   endfunction

endpackage

// File: rtl/m2vside_hdr_reg.sv
// Macroblock header holding register with load enable and asynchronous clear.
module m2vside_hdr_reg #(
   parameter int unsigned W = 50
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/m2vside1.sv
// Stage-1 side-information sequencer: expands each macroblock header into six
// per-block records, advancing on block_start, with one header of look-ahead.
module m2vside1
   import m2v_side_defs_pkg::*;
#(
   parameter int unsigned MVH_WIDTH = MVH_WIDTH_DEF,
   parameter int unsigned MVV_WIDTH = MVV_WIDTH_DEF,
   parameter int unsigned MBX_WIDTH = MBX_WIDTH_DEF,
   parameter int unsigned MBY_WIDTH = MBY_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mb_valid,
   output logic                 mb_ready,
   input  logic [MVH_WIDTH-1:0] mb_mv_h,
   input  logic [MVV_WIDTH-1:0] mb_mv_v,
   input  logic [MBX_WIDTH-1:0] mb_x,
   input  logic [MBY_WIDTH-1:0] mb_y,
   input  logic                 mb_intra,
   input  logic [5:0]           mb_cbp,
   input  logic                 block_start,
   output logic [MVH_WIDTH-1:0] s1_mv_h,
   output logic [MVV_WIDTH-1:0] s1_mv_v,
   output logic [MBX_WIDTH-1:0] s1_mb_x,
   output logic [MBY_WIDTH-1:0] s1_mb_y,
   output logic                 s1_mb_intra,
   output logic [2:0]           s1_block,
   output logic                 s1_coded,
   output logic                 s1_enable,
   output logic                 busy
);

   localparam int unsigned HW = hdr_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);

   side_state_t   state_q, state_d;
   logic [2:0]    blk_q, blk_d;
   logic          pend_v_q, pend_v_d;
   logic          accept, load_cur, load_pend, cur_from_pend;
   logic [HW-1:0] hdr_in, cur_d, cur_q, pend_q;
   logic [5:0]    cur_cbp, cbp_shift;

   assign hdr_in = {mb_mv_h, mb_mv_v, mb_x, mb_y, mb_intra, mb_cbp};
   assign accept = mb_valid & ~pend_v_q;
   assign cur_d  = cur_from_pend ? pend_q : hdr_in;

   m2vside_hdr_reg #(.W(HW)) u_cur (
      .clk(clk), .reset_n(reset_n), .load(load_cur), .d(cur_d), .q(cur_q)
   );

   m2vside_hdr_reg #(.W(HW)) u_pend (
      .clk(clk), .reset_n(reset_n), .load(load_pend), .d(hdr_in), .q(pend_q)
   );

   // Next-state: block advance, macroblock hand-over (pending or bypass) and idle entry
   always_comb begin
      state_d       = state_q;
      blk_d         = blk_q;
      load_cur      = 1'b0;
      load_pend     = 1'b0;
      cur_from_pend = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               load_cur = 1'b1;
               blk_d    = 3'd0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            load_pend = accept;
            if (block_start) begin
               if (blk_q < BLK_LAST) begin
                  blk_d = blk_q + 3'd1;
               end else begin
                  blk_d = 3'd0;
                  if (pend_v_q) begin
                     load_cur      = 1'b1;
                     cur_from_pend = 1'b1;
                  end else if (accept) begin
                     load_cur  = 1'b1;
                     load_pend = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            blk_d   = 3'd0;
         end
      endcase
      if (blk_q > BLK_LAST) blk_d = 3'd0;
      pend_v_d = (pend_v_q & ~cur_from_pend) | load_pend;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         blk_q    <= 3'd0;
         pend_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         blk_q    <= blk_d;
         pend_v_q <= pend_v_d;
      end
   end

   assign {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, cur_cbp} = cur_q;

   // cbp bit 5 belongs to block 0, so shift the current block's bit up to the MSB
   assign cbp_shift = cur_cbp << blk_q;
   assign s1_coded  = s1_mb_intra | cbp_shift[5];
   assign s1_block  = blk_q;
   assign s1_enable = (state_q == ST_RUN);
   assign mb_ready  = ~pend_v_q;
   assign busy      = s1_enable | pend_v_q;

   a_no_accept_when_pending: assert property (
      @(posedge clk) disable iff (!reset_n) !(mb_valid && mb_ready && pend_v_q));

endmodule

// File: tb/tb_m2vside1.sv
// Self-checking bench for m2vside1: directed table, test-plan sequences and
// random traffic against a queue-based model of outstanding macroblocks.
module tb_m2vside1;

   typedef struct {
      logic [15:0] mv_h;
      logic [14:0] mv_v;
      logic [5:0]  x;
      logic [4:0]  y;
      logic        intra;
      logic [5:0]  cbp;
   } hdr_t;

   typedef struct {
      logic       v;
      logic       bs;
      logic [5:0] x;
      logic [4:0] y;
      logic       intra;
      logic [5:0] cbp;
      logic       exp_en;
      logic [2:0] exp_blk;
      logic       exp_coded;
      logic       exp_ready;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mb_valid, mb_ready, mb_intra, block_start;
   logic [15:0] mb_mv_h, s1_mv_h;
   logic [14:0] mb_mv_v, s1_mv_v;
   logic [5:0]  mb_x, s1_mb_x, mb_cbp;
   logic [4:0]  mb_y, s1_mb_y;
   logic        s1_mb_intra, s1_coded, s1_enable, busy;
   logic [2:0]  s1_block;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: headers accepted but not fully consumed, and block position within the oldest
   hdr_t q[$];
   int   pos;
   hdr_t last_hdr;

   always #5 clk = ~clk;

   m2vside1 dut (
      .clk(clk), .reset_n(reset_n), .mb_valid(mb_valid), .mb_ready(mb_ready),
      .mb_mv_h(mb_mv_h), .mb_mv_v(mb_mv_v), .mb_x(mb_x), .mb_y(mb_y),
      .mb_intra(mb_intra), .mb_cbp(mb_cbp), .block_start(block_start),
      .s1_mv_h(s1_mv_h), .s1_mv_v(s1_mv_v), .s1_mb_x(s1_mb_x), .s1_mb_y(s1_mb_y),
      .s1_mb_intra(s1_mb_intra), .s1_block(s1_block), .s1_coded(s1_coded),
      .s1_enable(s1_enable), .busy(busy)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic hdr_t mk(input logic [5:0] x, input logic [4:0] y, input logic intra,
                               input logic [5:0] cbp);
      hdr_t h;
      h.mv_h  = 16'($urandom);
      h.mv_v  = 15'($urandom);
      h.x     = x;
      h.y     = y;
      h.intra = intra;
      h.cbp   = cbp;
      return h;
   endfunction

   function automatic logic coded_of(input hdr_t h, input int b);
      logic [5:0] c;
      c = h.cbp;
      return h.intra | c[5-b];
   endfunction

   task automatic model_reset();
      q.delete();
      pos      = 0;
      last_hdr = '{default: '0};
   endtask

   task automatic check_model(input string tag);
      chk({tag, " enable"}, s1_enable, q.size() > 0);
      chk({tag, " ready"}, mb_ready, q.size() < 2);
      chk({tag, " busy"}, busy, q.size() > 0);
      if (q.size() > 0) begin
         chk({tag, " block"}, s1_block, pos);
         chk({tag, " coded"}, s1_coded, coded_of(q[0], pos));
         chk({tag, " x"}, s1_mb_x, q[0].x);
         chk({tag, " y"}, s1_mb_y, q[0].y);
         chk({tag, " intra"}, s1_mb_intra, q[0].intra);
         chk({tag, " mv_h"}, s1_mv_h, q[0].mv_h);
         chk({tag, " mv_v"}, s1_mv_v, q[0].mv_v);
      end else begin
         chk({tag, " idle x"}, s1_mb_x, last_hdr.x);
         chk({tag, " idle y"}, s1_mb_y, last_hdr.y);
         chk({tag, " idle mv_h"}, s1_mv_h, last_hdr.mv_h);
      end
   endtask

   // Drive one cycle (called at a falling edge), advance the model, check at next falling edge
   task automatic step(input logic v, input logic bs, input hdr_t h, output logic acc,
                       input string tag);
      mb_valid    = v;
      block_start = bs;
      mb_mv_h     = h.mv_h;
      mb_mv_v     = h.mv_v;
      mb_x        = h.x;
      mb_y        = h.y;
      mb_intra    = h.intra;
      mb_cbp      = h.cbp;
      acc = v && (q.size() < 2);
      if (bs && q.size() > 0) begin
         pos++;
         if (pos == 6) begin
            last_hdr = q.pop_front();
            pos = 0;
         end
      end
      if (acc) q.push_back(h);
      @(negedge clk);
      check_model(tag);
   endtask

   vec_t tbl[7];

   initial begin
      hdr_t hA, hB, hC, hz, rh;
      logic acc, offer;

      hz = '{default: '0};
      mb_valid = 0; block_start = 0; mb_mv_h = 0; mb_mv_v = 0;
      mb_x = 0; mb_y = 0; mb_intra = 0; mb_cbp = 0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset enable", s1_enable, 0);
      chk("reset busy", busy, 0);
      chk("reset ready", mb_ready, 1);
      chk("reset block", s1_block, 0);
      chk("reset coded", s1_coded, 0);
      chk("reset x", s1_mb_x, 0);
      chk("reset mv_h", s1_mv_h, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic macroblock: x=3 y=2 non-intra, cbp 101001
      tbl[0] = '{1, 0, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd0, 1, 1};
      tbl[1] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd1, 0, 1};
      tbl[2] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd2, 1, 1};
      tbl[3] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd3, 0, 1};
      tbl[4] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd4, 0, 1};
      tbl[5] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 1, 3'd5, 1, 1};
      tbl[6] = '{0, 1, 6'd3, 5'd2, 0, 6'b101001, 0, 3'd0, 0, 1};
      hA = mk(6'd3, 5'd2, 1'b0, 6'b101001);
      for (int i = 0; i < 7; i++) begin
         hA.x = tbl[i].x; hA.y = tbl[i].y; hA.intra = tbl[i].intra; hA.cbp = tbl[i].cbp;
         step(tbl[i].v, tbl[i].bs, hA, acc, "tbl");
         chk($sformatf("tbl[%0d] enable", i), s1_enable, tbl[i].exp_en);
         chk($sformatf("tbl[%0d] ready", i), mb_ready, tbl[i].exp_ready);
         if (tbl[i].exp_en) begin
            chk($sformatf("tbl[%0d] block", i), s1_block, tbl[i].exp_blk);
            chk($sformatf("tbl[%0d] coded", i), s1_coded, tbl[i].exp_coded);
         end
      end

      // Intra with empty cbp: every block coded
      hA = mk(6'd10, 5'd7, 1'b1, 6'b000000);
      step(1, 0, hA, acc, "intra");
      for (int i = 0; i < 6; i++) begin
         if (s1_enable) chk("intra coded", s1_coded, 1);
         step(0, 1, hz, acc, "intra");
      end
      chk("intra end enable", s1_enable, 0);

      // Second header during block 2: no bubble at the hand-over
      hA = mk(6'd1, 5'd1, 1'b0, 6'b111111);
      hB = mk(6'd44, 5'd20, 1'b0, 6'b010101);
      step(1, 0, hA, acc, "pend");
      step(0, 1, hz, acc, "pend");
      step(0, 1, hz, acc, "pend");
      step(1, 0, hB, acc, "pend");
      chk("pend accepted", acc, 1);
      chk("pend ready low", mb_ready, 0);
      for (int i = 0; i < 3; i++) step(0, 1, hz, acc, "pend");
      chk("pend blk5", s1_block, 5);
      step(0, 1, hz, acc, "pend");
      chk("handover enable", s1_enable, 1);
      chk("handover block", s1_block, 0);
      chk("handover x", s1_mb_x, 44);
      chk("handover y", s1_mb_y, 20);
      chk("handover ready", mb_ready, 1);

      // Bypass: new header accepted on the last block_start of B
      for (int i = 0; i < 5; i++) step(0, 1, hz, acc, "byp");
      hC = mk(6'd9, 5'd30, 1'b0, 6'b100000);
      step(1, 1, hC, acc, "byp");
      chk("bypass enable", s1_enable, 1);
      chk("bypass block", s1_block, 0);
      chk("bypass x", s1_mb_x, 9);
      chk("bypass ready", mb_ready, 1);
      for (int i = 0; i < 6; i++) step(0, 1, hz, acc, "byp");

      // block_start while idle changes nothing
      step(0, 1, hz, acc, "idle");
      step(0, 1, hz, acc, "idle");
      chk("idle enable", s1_enable, 0);
      chk("idle x held", s1_mb_x, 9);

      // Random traffic; header held stable while offered
      offer = 0;
      rh = hz;
      for (int n = 0; n < 400; n++) begin
         if (!offer && ($urandom_range(0, 2) == 0)) begin
            offer = 1;
            rh = mk(6'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0), 6'($urandom));
         end
         step(offer, 1'($urandom), rh, acc, "rand");
         if (acc) offer = 0;
      end
      while (q.size() > 0) step(0, 1, hz, acc, "drain");

      // Asynchronous reset at block 3 with a pending header
      hA = mk(6'd5, 5'd6, 1'b0, 6'b001100);
      hB = mk(6'd7, 5'd8, 1'b1, 6'b000011);
      step(1, 0, hA, acc, "arst");
      step(0, 1, hz, acc, "arst");
      step(0, 1, hz, acc, "arst");
      step(1, 1, hB, acc, "arst");
      chk("arst blk3", s1_block, 3);
      chk("arst pending", mb_ready, 0);
      mb_valid = 0; block_start = 0;
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst enable", s1_enable, 0);
      chk("arst busy", busy, 0);
      chk("arst ready", mb_ready, 1);
      chk("arst block", s1_block, 0);
      chk("arst x", s1_mb_x, 0);
      chk("arst intra", s1_mb_intra, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 1, hz, acc, "post");
      step(1, 0, hC, acc, "post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
